demux_2s_reg: RTL and testbench



---
 rtl/demux_2s_reg.sv | 76 +++++++
 tb/tb_demux_2s_reg.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_2s_reg.sv
// demux_2s_reg: registered 1-to-4 valid/ready stream demultiplexer, one holding register per channel.
// Latency 1 cycle; in_ready drops only while the selected channel is full and its consumer is stalled.
// Optional per-channel delivery counters on o_cnt when DEMUX_2S_STATS_EN is defined.
module demux_2s_reg #(
   parameter int width = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [width-1:0] d,
   input  logic [1:0]       s,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [width-1:0] o0,
   output logic [width-1:0] o1,
   output logic [width-1:0] o2,
   output logic [width-1:0] o3,
   output logic [3:0]       o_valid,
`ifdef DEMUX_2S_STATS_EN
   output logic [31:0]      o_cnt,
`endif
   input  logic [3:0]       o_ready
);

   logic [width-1:0] r_dat [4];
   logic [3:0]       r_vld;
   logic [3:0]       w_dlv;
   logic [3:0]       w_ld;
   logic             w_rdy;
   logic             w_acc;

   // Only the selected channel gates acceptance; the others drain independently.
   always_comb begin
      w_rdy    = ~r_vld[s] | o_ready[s];
      w_acc    = in_valid & w_rdy;
      w_dlv    = r_vld & o_ready;
      w_ld     = 4'b0000;
      w_ld[s]  = w_acc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) r_dat[k] <= '0;
         r_vld <= 4'b0000;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (w_ld[k]) r_dat[k] <= d;
         end
         r_vld <= w_ld | (r_vld & ~w_dlv);
      end
   end

   assign in_ready = w_rdy;
   assign o0       = r_dat[0];
   assign o1       = r_dat[1];
   assign o2       = r_dat[2];
   assign o3       = r_dat[3];
   assign o_valid  = r_vld;

`ifdef DEMUX_2S_STATS_EN
   logic [7:0] r_cnt [4];

   // Counts deliveries, not accepts; 8-bit wrap is intended.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) r_cnt[k] <= 8'd0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (w_dlv[k]) r_cnt[k] <= r_cnt[k] + 8'd1;
         end
      end
   end

   assign o_cnt = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};
`endif

endmodule

// File: tb/tb_demux_2s_reg.sv
// Bench for demux_2s_reg: directed scenarios plus randomized traffic against a per-channel slot model.
module tb_demux_2s_reg;

   logic       clk;
   logic       rst_n;
   logic [3:0] d;
   logic [1:0] s;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] o0, o1, o2, o3;
   logic [3:0] o_valid;
   logic [3:0] o_ready;
`ifdef DEMUX_2S_STATS_EN
   logic [31:0] o_cnt;
`endif

   int total = 0;
   int bad   = 0;

   logic [3:0] m_dat [4];
   bit   [3:0] m_vld;
   int         m_cnt [4];

   demux_2s_reg #(.width(4)) dut (
      .clk(clk), .rst_n(rst_n), .d(d), .s(s), .in_valid(in_valid), .in_ready(in_ready),
      .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o_valid(o_valid),
`ifdef DEMUX_2S_STATS_EN
      .o_cnt(o_cnt),
`endif
      .o_ready(o_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [3:0] dut_o(int k);
      case (k)
         0: return o0;
         1: return o1;
         2: return o2;
         default: return o3;
      endcase
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 4; k++) begin
         m_dat[k] = 4'd0;
         m_cnt[k] = 0;
      end
      m_vld = 4'b0000;
   endtask

   function automatic bit m_ready(logic [1:0] sel, logic [3:0] rdy);
      return !m_vld[sel] || rdy[sel];
   endfunction

   // Advance one clock and apply the transfer rules to the model: a full slot empties when its
   // consumer is ready, and an accepted word lands in the selected slot.
   task automatic step();
      bit         acc;
      logic [3:0] rdy;
      logic [1:0] sel;
      logic [3:0] dat;
      rdy = o_ready;
      sel = s;
      dat = d;
      acc = in_valid && m_ready(sel, rdy);
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         if (m_vld[k] && rdy[k]) begin
            m_vld[k] = 1'b0;
            m_cnt[k] = (m_cnt[k] + 1) % 256;
         end
      end
      if (acc) begin
         m_dat[sel] = dat;
         m_vld[sel] = 1'b1;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; d = 4'd0; s = 2'd0; o_ready = 4'b0000;
      m_reset();
      #2;
      total++;
      if (o_valid !== 4'b0000) begin bad++; $display("FAIL reset_valid got=%b want=0000", o_valid); end
      total++;
      if ({o3, o2, o1, o0} !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h want=0000", {o3, o2, o1, o0}); end
      for (int k = 0; k < 4; k++) begin
         s = 2'(k);
         #1;
         total++;
         if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready s=%0d got=%b want=1", k, in_ready); end
      end
      #5 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_pulse();
      o_ready = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         logic [3:0] w;
         w = 4'd1 << k;
         in_valid = 1'b1; s = 2'(k); d = w;
         #1;
         total++;
         if (in_ready !== 1'b1) begin bad++; $display("FAIL pulse_in_ready s=%0d got=%b want=1", k, in_ready); end
         step();
         total++;
         if (dut_o(k) !== w || o_valid !== w) begin
            bad++; $display("FAIL pulse_out ch=%0d got=%h/%b want=%h/%b", k, dut_o(k), o_valid, w, w);
         end
      end
      in_valid = 1'b0;
      step();
      total++;
      if (o_valid !== 4'b0000) begin bad++; $display("FAIL pulse_drain got=%b want=0000", o_valid); end
   endtask

   task automatic test_stall();
      o_ready = 4'b0000; in_valid = 1'b1; s = 2'd2; d = 4'd3;
      step();
      total++;
      if (o2 !== 4'd3 || o_valid !== 4'b0100) begin bad++; $display("FAIL stall_first got=%h/%b want=3/0100", o2, o_valid); end
      d = 4'd5;
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
      step();
      total++;
      if (o2 !== 4'd3) begin bad++; $display("FAIL stall_hold got=%h want=3", o2); end
      o_ready = 4'b0100;
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_rdy got=%b want=1", in_ready); end
      step();
      total++;
      if (o2 !== 4'd5 || o_valid !== 4'b0100) begin bad++; $display("FAIL stall_reload got=%h/%b want=5/0100", o2, o_valid); end
      in_valid = 1'b0; o_ready = 4'b0000;
      step();
   endtask

   task automatic test_isolation();
      in_valid = 1'b1; s = 2'd1; d = 4'd7;
      step();
      s = 2'd0; d = 4'd9;
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL iso_in_ready got=%b want=1", in_ready); end
      step();
      total++;
      if (o0 !== 4'd9 || o1 !== 4'd7 || o_valid !== 4'b0111) begin
         bad++; $display("FAIL iso_state got=%h,%h/%b want=9,7/0111", o0, o1, o_valid);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_drain_all();
      in_valid = 1'b1; s = 2'd3; d = 4'hA;
      step();
      in_valid = 1'b0;
      total++;
      if (o_valid !== 4'b1111) begin bad++; $display("FAIL fill_all got=%b want=1111", o_valid); end
      o_ready = 4'b1111;
      step();
      o_ready = 4'b0000;
      total++;
      if (o_valid !== 4'b0000) begin bad++; $display("FAIL drain_all got=%b want=0000", o_valid); end
      total++;
      if ({o3, o2, o1, o0} !== 16'hA579) begin bad++; $display("FAIL drain_keep_data got=%h want=a579", {o3, o2, o1, o0}); end
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; s = 2'(k); d = 4'(k + 12);
         step();
      end
      in_valid = 1'b0;
      total++;
      if (o_valid !== 4'b1111) begin bad++; $display("FAIL prereset_fill got=%b want=1111", o_valid); end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (o_valid !== 4'b0000 || {o3, o2, o1, o0} !== 16'h0000) begin
         bad++; $display("FAIL async_reset got=%b/%h want=0000/0000", o_valid, {o3, o2, o1, o0});
      end
      m_reset();
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      bit acc;
      acc = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!in_valid || acc) begin
            in_valid = ($urandom_range(0, 3) != 0);
            s = 2'($urandom_range(0, 3));
            d = 4'($urandom_range(0, 15));
         end
         o_ready = 4'($urandom_range(0, 15));
         #1;
         acc = in_valid && m_ready(s, o_ready);
         total++;
         if (in_ready !== m_ready(s, o_ready)) begin
            bad++; $display("FAIL rand_in_ready i=%0d got=%b want=%b", i, in_ready, m_ready(s, o_ready));
         end
         step();
         total++;
         if (o_valid !== m_vld) begin bad++; $display("FAIL rand_valid i=%0d got=%b want=%b", i, o_valid, m_vld); end
         for (int k = 0; k < 4; k++) begin
            total++;
            if (dut_o(k) !== m_dat[k]) begin bad++; $display("FAIL rand_data i=%0d ch=%0d got=%h want=%h", i, k, dut_o(k), m_dat[k]); end
         end
`ifdef DEMUX_2S_STATS_EN
         total++;
         if (o_cnt !== {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])}) begin
            bad++; $display("FAIL rand_cnt i=%0d got=%h", i, o_cnt);
         end
`endif
      end
      in_valid = 1'b0; o_ready = 4'b0000;
   endtask

`ifdef DEMUX_2S_STATS_EN
   task automatic test_stats();
      #2 rst_n = 1'b0;
      #1 m_reset();
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      o_ready = 4'b1000; in_valid = 1'b1; s = 2'd3;
      for (int i = 0; i < 257; i++) begin
         d = 4'(i);
         step();
      end
      in_valid = 1'b0;
      step();
      o_ready = 4'b0000;
      total++;
      if (o_cnt !== 32'h0100_0000) begin bad++; $display("FAIL stats_wrap got=%h want=01000000", o_cnt); end
      total++;
      if (o_cnt[31:24] !== 8'(m_cnt[3])) begin bad++; $display("FAIL stats_model got=%h want=%h", o_cnt[31:24], 8'(m_cnt[3])); end
   endtask
`endif

   initial begin
      test_reset();
      test_pulse();
      test_stall();
      test_isolation();
      test_drain_all();
      test_async_reset();
      test_random();
`ifdef DEMUX_2S_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
